// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the CPU inst and data sram-like channels onto one
// memory port. Data wins over inst; a request that is waiting for addr_ok
// keeps the port until it is accepted. Accepted transactions are tracked in
// an in-order ID FIFO so responses are routed back to the issuing channel.
//
// state    | meaning
// S_IDLE   | no request held; grant follows data-over-inst priority
// S_LOCKED | owner's request is stalled on mem_addr_ok; port held for owner
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic [31:0]      inst_rdata,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic [31:0]      data_rdata,
  output logic             data_data_ok,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_data_ok,
  output logic [PTR_W:0]   outstanding,
  output logic             arb_err
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;     // 1 = DATA, 0 = INST
  logic             grant_valid;
  logic             grant_data;
  logic             grant_req;
  logic             full;
  logic             hs;
  logic             pop;
  logic             head;
  logic [DEPTH-1:0] id_q;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign outstanding = count;
  assign head        = id_q[rd_ptr];
  assign pop         = mem_data_ok & (count != '0);

  // Lock state register; owner only changes when a new lock is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Grant selection, memory-side mux, handshakes and lock next-state
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    grant_valid  = 1'b0;
    grant_data   = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;

    if (state == S_LOCKED) begin
      grant_valid = 1'b1;
      grant_data  = owner;
    end else if (data_req) begin
      grant_valid = 1'b1;
      grant_data  = 1'b1;
    end else if (inst_req) begin
      grant_valid = 1'b1;
      grant_data  = 1'b0;
    end

    grant_req = grant_valid & (grant_data ? data_req : inst_req);
    mem_req   = grant_req & ~full;
    hs        = mem_req & mem_addr_ok;

    // With no grant the fields simply follow inst
    mem_wr    = grant_data ? data_wr    : inst_wr;
    mem_size  = grant_data ? data_size  : inst_size;
    mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    mem_addr  = grant_data ? data_addr  : inst_addr;
    mem_wdata = grant_data ? data_wdata : inst_wdata;

    inst_addr_ok = hs & ~grant_data;
    data_addr_ok = hs &  grant_data;

    case (state)
      S_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt = S_LOCKED;
          owner_nxt = grant_data;
        end
      end
      S_LOCKED: begin
        // Release on accept, or if the owner abandons its request
        if (hs || !grant_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // In-order ID FIFO: push on accept, pop on each response
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (hs) begin
        id_q[wr_ptr] <= grant_data;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({hs, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error for a response that has no matching transaction
  always_ff @(posedge clk) begin
    if (reset) arb_err <= 1'b0;
    else if (mem_data_ok && count == '0) arb_err <= 1'b1;
  end

  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios followed by a randomized
// phase, each cycle compared against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size;
  logic [3:0] inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_addr_ok, mem_data_ok;
  logic [PTR_W:0] outstanding;
  logic arb_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: queue of channel IDs (1=data, 0=inst), current lock
  // holder (-1 = none) and the sticky error flag.
  bit idq[$];
  int lock_owner = -1;
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok),
    .outstanding(outstanding), .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs mid-cycle, then advance the model to the next edge.
  task automatic tick();
    bit full, req_of_who, exp_req, accept, resp, hd;
    int who;
    logic [38:0] exp_ctl;
    @(negedge clk);
    full = (idq.size() == DEPTH);
    if (lock_owner >= 0) who = lock_owner;
    else if (data_req)   who = 1;
    else if (inst_req)   who = 0;
    else                 who = -1;
    req_of_who = (who == 1) ? data_req : (who == 0) ? inst_req : 1'b0;
    exp_req = req_of_who && !full;
    accept  = exp_req && mem_addr_ok;
    resp    = mem_data_ok && (idq.size() > 0);
    hd      = (idq.size() > 0) ? idq[0] : 1'b0;
    exp_ctl = (who == 1) ? {data_wr, data_size, data_wstrb, data_addr}
                         : {inst_wr, inst_size, inst_wstrb, inst_addr};

    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("mem_addr", mem_addr, exp_ctl[31:0]);
    check("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'(exp_ctl[38:32]));
    check("mem_wdata", mem_wdata, (who == 1) ? data_wdata : inst_wdata);
    check("inst_addr_ok", 32'(inst_addr_ok), 32'(accept && who == 0));
    check("data_addr_ok", 32'(data_addr_ok), 32'(accept && who == 1));
    check("inst_data_ok", 32'(inst_data_ok), 32'(resp && !hd));
    check("data_data_ok", 32'(data_data_ok), 32'(resp && hd));
    check("inst_rdata", inst_rdata, mem_rdata);
    check("data_rdata", data_rdata, mem_rdata);
    check("outstanding", 32'(outstanding), 32'(idq.size()));
    check("arb_err", 32'(arb_err), 32'(err_m));

    if (reset) begin
      idq.delete();
      lock_owner = -1;
      err_m = 1'b0;
    end else begin
      if (mem_data_ok && idq.size() == 0) err_m = 1'b1;
      if (resp) void'(idq.pop_front());
      if (accept) idq.push_back(who == 1);
      if (lock_owner < 0) begin
        if (exp_req && !mem_addr_ok) lock_owner = who;
      end else if (accept || !req_of_who) begin
        lock_owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  initial begin
    reset = 1; quiet();
    inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = 32'hBFC00000; inst_wdata = 0;
    data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF; data_addr = 32'h80001000; data_wdata = 0;
    mem_rdata = 0;
    tick(); tick();
    reset = 0;
    tick();

    // Single inst read
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    tick();
    check("single_outstanding", 32'(outstanding), 32'd1);
    quiet(); tick();
    mem_data_ok = 1; mem_rdata = 32'h3C010001;
    #1 check("single_inst_data_ok", 32'(inst_data_ok), 32'd1);
    tick();
    quiet(); tick();
    check("single_drained", 32'(outstanding), 32'd0);

    // Simultaneous requests: data first, then inst
    inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'h3;
    data_addr = 32'h80002000; data_wdata = 32'hDEADBEEF; mem_addr_ok = 1;
    tick();
    data_req = 0; tick();
    quiet(); mem_data_ok = 1; mem_rdata = 32'h11111111; tick();
    mem_rdata = 32'h22222222; tick();
    quiet(); tick();

    // Stalled inst keeps the port even when data arrives
    inst_req = 1; inst_addr = 32'hBFC00010; data_wr = 0; tick();
    data_req = 1; data_addr = 32'h80003000; tick();
    tick();
    mem_addr_ok = 1; tick();
    inst_req = 0; tick();
    quiet(); mem_data_ok = 1; tick(); tick();
    quiet(); tick();

    // Fill to DEPTH, block the next request, release one slot
    mem_addr_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_req = i[0]; data_req = ~i[0];
      inst_addr = 32'h1000 + 32'(i); data_addr = 32'h2000 + 32'(i);
      tick();
    end
    inst_req = 0; data_req = 1; data_addr = 32'h2100;
    tick();
    mem_data_ok = 1; tick();
    mem_data_ok = 0; tick();
    quiet(); mem_data_ok = 1;
    for (int i = 0; i < DEPTH; i++) tick();
    quiet(); tick();

    // Response with nothing outstanding
    mem_data_ok = 1; tick();
    quiet(); tick(); tick();

    // Reset with two outstanding, then a stale response
    inst_req = 1; data_req = 1; mem_addr_ok = 1; tick(); tick();
    quiet(); reset = 1; tick();
    reset = 0; mem_data_ok = 1; tick();
    quiet(); tick();

    // Randomized traffic
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 400; c++) begin
      inst_req    = ($urandom_range(0, 2) != 0);
      data_req    = ($urandom_range(0, 2) == 0);
      inst_wr     = $urandom_range(0, 1);
      data_wr     = $urandom_range(0, 1);
      inst_size   = 2'($urandom_range(0, 3));
      data_size   = 2'($urandom_range(0, 3));
      inst_wstrb  = 4'($urandom);
      data_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = ($urandom_range(0, 1) == 1);
      mem_rdata   = $urandom;
      mem_data_ok = (idq.size() > 0) && ($urandom_range(0, 2) == 0);
      if (c == 250) mem_data_ok = (idq.size() == 0);
      reset       = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0; quiet(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
